nco_tune_ctrl: RTL and testbench
================================

// Module: nco_tune_ctrl
// PURPOSE
//   Tuning controller for the receive-path NCO (32-bit phase increment, 16-bit sin/cos).
//   Shares the NCO between two requesters: direct host tuning, and a linear frequency-sweep engine.
//   Drives the NCO phase increment and clock enable.
//   After every retune, tracks the NCO pipeline flush and flags when sin/cos reflect the new frequency.
// PARAMETERS
//   PHI_W    32  NCO phase-increment width (phi_inc bits)
//   CNT_W    16  width of sweep step count, step index and dwell counters
//   SETTLE   12  NCO output-valid cycles to discard after a phase-increment change (NCO latency)
// PORTS
//   clk            in   1      system clock, single domain
//   reset          in   1      asynchronous, active-high reset
//   host_req       in   1      host tune request, 1-cycle strobe
//   host_phi       in   PHI_W  phase increment for host tune
//   host_ack       out  1      1-cycle pulse: host_phi applied to NCO
//   sweep_start    in   1      strobe: begin sweep
//   sweep_abort    in   1      strobe: stop sweep, hold current frequency
//   sweep_base     in   PHI_W  first phase increment of sweep
//   sweep_step     in   PHI_W  increment added per step (two's-complement allowed: down-sweep)
//   sweep_count    in   CNT_W  number of sweep points
//   sweep_dwell    in   CNT_W  tuned cycles held at each point
//   nco_phi_inc    out  PHI_W  to NCO phi_inc_i
//   nco_clken      out  1      to NCO clken
//   nco_out_valid  in   1      from NCO out_valid
//   tuned          out  1      NCO output valid at current nco_phi_inc
//   sweep_busy     out  1      sweep in progress
//   sweep_done     out  1      1-cycle pulse: last sweep point finished its dwell
//   step_idx       out  CNT_W  current sweep point index, 0-based
// BEHAVIOUR
//   Reset: nco_phi_inc=0, nco_clken=0, tuned=0, host_ack=0, sweep_busy=0, sweep_done=0, step_idx=0, state IDLE.
//   - nco_clken: registered; 1 from the first clk edge after reset deasserts; stays 1.
//   States: IDLE, SETTLE, HOLD, DWELL.
//   - IDLE: no frequency applied since reset.
//   - HOLD: tuned, no sweep running.
//   Retune (any source): nco_phi_inc updates on the edge after the request cycle; tuned=0 the same edge.
//   - Settle counter loads SETTLE and decrements on each cycle with nco_out_valid=1.
//   - tuned=1 on the edge after the decrement that reaches 0.
//   - Retune during SETTLE reloads the counter.
//   Host tune, accepted in every state:
//   - nco_phi_inc<=host_phi, host_ack=1 for one cycle, state SETTLE.
//   - If sweeping: sweep_busy<=0, no sweep_done, step_idx holds its value.
//   Sweep start, accepted only in IDLE/HOLD and only with host_req=0 (ignored otherwise):
//   - latch step/count/dwell; nco_phi_inc<=sweep_base, step_idx<=0, sweep_busy<=1, state SETTLE.
//   SETTLE done: HOLD if !sweep_busy, else DWELL with dwell counter loaded.
//   DWELL:
//   - Count max(sweep_dwell,1) cycles.
//   - Then, if step_idx==max(sweep_count,1)-1: sweep_done=1 for 1 cycle, sweep_busy<=0, HOLD at last frequency.
//   - Otherwise: nco_phi_inc<=nco_phi_inc+step (mod 2^PHI_W, wraps silently), step_idx++, SETTLE.
//   sweep_abort while busy: sweep_busy<=0, no sweep_done, frequency kept.
//   - From DWELL: go to HOLD.
//   - From SETTLE: remain until settled, then HOLD.
//   - Abort when not busy: ignored.
//   Simultaneous events:
//   - host_req beats sweep_start and sweep_abort.
//   - sweep_abort beats the DWELL step/done decision in the same cycle.
//   Reset mid-sweep: all outputs return to reset values immediately (asynchronous).
// STRUCTURE
//   Package nco_ctrl_pkg: state enum (IDLE, SETTLE, HOLD, DWELL); PHI_W/CNT_W defaults.
//   Sub-module settle_timer: loadable down-counter with enable and done flag.
//   - Two instances: settle counter (enable=nco_out_valid), dwell counter (enable=1).
// TESTING
//   1 Reset, then host_req with host_phi=32'h0F5C28F6
//     -> nco_phi_inc=32'h0F5C28F6 next cycle, host_ack 1 cycle,
//        tuned rises after 12 valid cycles.
//   2 Sweep base=32'h1000_0000, step=32'h0100_0000, count=4, dwell=8
//     -> phi 0x10,0x11,0x12,0x13 (<<24), each tuned 8 cycles;
//        sweep_done once; step_idx ends at 3.
//   3 base=32'hFF00_0000, step=32'h0100_0000, count=3
//     -> phi FF00_0000, 0000_0000, 0100_0000 (wrap), no error.
//   4 host_req during sweep step 2
//     -> sweep_busy drops, no sweep_done, phi=host_phi.
//   5 sweep_abort in DWELL at step 1 -> HOLD at step-1 frequency, tuned stays 1;
//     sweep_start and host_req same cycle -> host wins, sweep not started.
//   6 nco_out_valid held 0 during SETTLE -> tuned stays 0;
//     reset asserted mid-sweep -> all outputs return to reset values.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the receive-path NCO tuning controller.
package nco_ctrl_pkg;

  localparam int unsigned PHI_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned SETTLE_DEF = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD,
    S_DWELL
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter: load wins over enable, stops at zero, o_done while zero.
module settle_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/nco_tune_ctrl.sv
// NCO tuning controller: arbitrates host tuning against a linear sweep engine and
// reports when the NCO output reflects the current phase increment.
module nco_tune_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned PHI_W  = PHI_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_req,
  input  logic [PHI_W-1:0] host_phi,
  output logic             host_ack,
  input  logic             sweep_start,
  input  logic             sweep_abort,
  input  logic [PHI_W-1:0] sweep_base,
  input  logic [PHI_W-1:0] sweep_step,
  input  logic [CNT_W-1:0] sweep_count,
  input  logic [CNT_W-1:0] sweep_dwell,
  output logic [PHI_W-1:0] nco_phi_inc,
  output logic             nco_clken,
  input  logic             nco_out_valid,
  output logic             tuned,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] step_idx
);

  state_t           r_state;
  logic [PHI_W-1:0] r_phi;
  logic [PHI_W-1:0] r_step;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_step_idx;
  logic             r_clken;
  logic             r_ack;
  logic             r_tuned;
  logic             r_busy;
  logic             r_done;

  logic             w_start_ok;
  logic             w_step;
  logic             w_last;
  logic             w_settle_load;
  logic             w_settle_exit;
  logic             w_settle_done;
  logic             w_dwell_done;
  logic [CNT_W-1:0] w_last_idx;
  logic [CNT_W-1:0] w_dwell_load_val;

  // Zero count/dwell behave as one point / one cycle.
  assign w_last_idx       = (r_count == '0) ? '0 : r_count - CNT_W'(1);
  assign w_dwell_load_val = (r_dwell == '0) ? '0 : r_dwell - CNT_W'(1);
  assign w_last           = (r_step_idx == w_last_idx);

  // Timer load strobes mirror the FSM priorities below (host > abort > dwell decision).
  assign w_start_ok    = sweep_start && !host_req && ((r_state == S_IDLE) || (r_state == S_HOLD));
  assign w_step        = !host_req && (r_state == S_DWELL) && !sweep_abort && w_dwell_done && !w_last;
  assign w_settle_load = host_req || w_start_ok || w_step;
  assign w_settle_exit = !host_req && (r_state == S_SETTLE) && w_settle_done;

  settle_timer #(.W(CNT_W)) u_settle (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_settle_load),
    .i_load_val (CNT_W'(SETTLE)),
    .i_en       (nco_out_valid),
    .o_done     (w_settle_done)
  );

  settle_timer #(.W(CNT_W)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_settle_exit),
    .i_load_val (w_dwell_load_val),
    .i_en       (1'b1),
    .o_done     (w_dwell_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phi      <= '0;
      r_step     <= '0;
      r_count    <= '0;
      r_dwell    <= '0;
      r_step_idx <= '0;
      r_clken    <= 1'b0;
      r_ack      <= 1'b0;
      r_tuned    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clken <= 1'b1;
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      if (host_req) begin
        r_phi   <= host_phi;
        r_ack   <= 1'b1;
        r_tuned <= 1'b0;
        r_busy  <= 1'b0;
        r_state <= S_SETTLE;
      end else begin
        unique case (r_state)
          S_IDLE, S_HOLD: begin
            if (w_start_ok) begin
              r_step     <= sweep_step;
              r_count    <= sweep_count;
              r_dwell    <= sweep_dwell;
              r_phi      <= sweep_base;
              r_step_idx <= '0;
              r_busy     <= 1'b1;
              r_tuned    <= 1'b0;
              r_state    <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (sweep_abort) r_busy <= 1'b0;
            if (w_settle_done) begin
              r_tuned <= 1'b1;
              r_state <= (r_busy && !sweep_abort) ? S_DWELL : S_HOLD;
            end
          end
          S_DWELL: begin
            if (sweep_abort) begin
              r_busy  <= 1'b0;
              r_state <= S_HOLD;
            end else if (w_dwell_done) begin
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_HOLD;
              end else begin
                r_phi      <= r_phi + r_step;
                r_step_idx <= r_step_idx + CNT_W'(1);
                r_tuned    <= 1'b0;
                r_state    <= S_SETTLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign nco_phi_inc = r_phi;
  assign nco_clken   = r_clken;
  assign host_ack    = r_ack;
  assign tuned       = r_tuned;
  assign sweep_busy  = r_busy;
  assign sweep_done  = r_done;
  assign step_idx    = r_step_idx;

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Scoreboard bench for nco_tune_ctrl: stimulus queues expected ACK/TUNED/DONE events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_nco_tune_ctrl;

  localparam int unsigned SETTLE = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_req = 1'b0;
  logic [31:0] host_phi = '0;
  logic        sweep_start = 1'b0;
  logic        sweep_abort = 1'b0;
  logic [31:0] sweep_base = '0;
  logic [31:0] sweep_step = '0;
  logic [15:0] sweep_count = '0;
  logic [15:0] sweep_dwell = '0;
  logic        nco_out_valid = 1'b0;
  logic        host_ack;
  logic [31:0] nco_phi_inc;
  logic        nco_clken;
  logic        tuned;
  logic        sweep_busy;
  logic        sweep_done;
  logic [15:0] step_idx;

  nco_tune_ctrl #(.PHI_W(32), .CNT_W(16), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_phi(host_phi), .host_ack(host_ack),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .sweep_base(sweep_base), .sweep_step(sweep_step),
    .sweep_count(sweep_count), .sweep_dwell(sweep_dwell),
    .nco_phi_inc(nco_phi_inc), .nco_clken(nco_clken), .nco_out_valid(nco_out_valid),
    .tuned(tuned), .sweep_busy(sweep_busy), .sweep_done(sweep_done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_ACK, EV_TUNED, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] phi;
    logic [15:0] idx;
    logic        busy;
    int unsigned hold;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_idx = '0;
  logic [31:0] m_phi = '0;
  bit          valid_force0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [31:0] phi, input logic [15:0] idx,
                      input logic busy, input int unsigned hold);
    ev_t e;
    e.kind = k; e.phi = phi; e.idx = idx; e.busy = busy; e.hold = hold;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_kind_t k, output ev_t e, output bit ok);
    e = '{kind: EV_ACK, phi: '0, idx: '0, busy: 1'b0, hold: 0};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      ok = 1'b0;
      $display("FAIL unexpected_event: actual=%s expected=none", k.name());
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
      check("event_kind", 32'(k), 32'(e.kind));
    end
  endtask

  // NCO valid source: random, or forced low for the starved-settle case
  initial begin
    forever begin
      @(posedge clk);
      #1;
      nco_out_valid = valid_force0 ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: vcnt = valid samples taken at edges since the last retune edge,
  // hcnt = cycles tuned has been high.
  int unsigned vcnt = 0, vcnt_prev = 0, hcnt = 0, cur_hold = 0;
  logic        prev_tuned = 1'b0, prev_valid = 1'b0;
  logic [31:0] prev_phi = '0;
  ev_t         mon_e;
  bit          mon_ok;

  always @(negedge clk) begin : mon
    if (reset) begin
      vcnt = 0; hcnt = 0; cur_hold = 0;
      prev_tuned = 1'b0; prev_valid = 1'b0; prev_phi = '0;
    end else begin
      vcnt_prev = vcnt;
      vcnt += (prev_valid ? 1 : 0);
      if (prev_tuned) hcnt++;
      if (!tuned && prev_tuned) begin
        if (cur_hold != 0) check("dwell_len", hcnt, cur_hold);
        cur_hold = 0;
      end
      if (sweep_done) begin
        take(EV_DONE, mon_e, mon_ok);
        if (mon_ok) begin
          check("done_phi", nco_phi_inc, mon_e.phi);
          check("done_idx", 32'(step_idx), 32'(mon_e.idx));
          check("done_busy", 32'(sweep_busy), 32'(mon_e.busy));
        end
        if (cur_hold != 0) check("dwell_len_last", hcnt, cur_hold);
        cur_hold = 0;
      end
      if (host_ack) begin
        take(EV_ACK, mon_e, mon_ok);
        if (mon_ok) begin
          check("ack_phi", nco_phi_inc, mon_e.phi);
          check("ack_idx", 32'(step_idx), 32'(mon_e.idx));
          check("ack_busy", 32'(sweep_busy), 32'(mon_e.busy));
        end
      end
      if (tuned && !prev_tuned) begin
        take(EV_TUNED, mon_e, mon_ok);
        if (mon_ok) begin
          check("tuned_phi", nco_phi_inc, mon_e.phi);
          check("tuned_idx", 32'(step_idx), 32'(mon_e.idx));
          check("tuned_busy", 32'(sweep_busy), 32'(mon_e.busy));
          cur_hold = mon_e.hold;
        end
        check("settle_valids", vcnt_prev, SETTLE);
        hcnt = 0;
      end
      if (host_ack || (nco_phi_inc != prev_phi) || (!tuned && prev_tuned)) vcnt = 0;
      prev_valid = nco_out_valid;
      prev_tuned = tuned;
      prev_phi   = nco_phi_inc;
    end
  end

  task automatic drain();
    for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic hold_check();
    repeat (10) @(negedge clk);
    check("hold_tuned", 32'(tuned), 32'd1);
    check("hold_busy", 32'(sweep_busy), 32'd0);
    check("hold_phi", nco_phi_inc, m_phi);
    check("hold_idx", 32'(step_idx), 32'(m_idx));
  endtask

  task automatic wait_point(input logic [15:0] k, input logic want_tuned);
    bit ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (step_idx == k && tuned == want_tuned && sweep_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_point", 32'(ok), 32'd1);
  endtask

  task automatic do_host(input logic [31:0] phi, input bit expect_tuned);
    push(EV_ACK, phi, m_idx, 1'b0, 0);
    if (expect_tuned) push(EV_TUNED, phi, m_idx, 1'b0, 0);
    host_phi = phi;
    host_req = 1'b1;
    @(posedge clk); #1;
    host_req = 1'b0;
    m_phi = phi;
  endtask

  // mode 0: run to completion; 1: host tune at point k; 2: abort in dwell at k; 3: abort in settle at k
  task automatic run_sweep(input logic [31:0] base, input logic [31:0] step, input logic [15:0] count,
                           input logic [15:0] dwell, input int mode, input int k);
    int unsigned n, d, stop;
    logic [31:0] phi;
    logic [31:0] hphi;
    n    = (count == 0) ? 1 : int'(count);
    d    = (dwell == 0) ? 1 : int'(dwell);
    stop = (mode == 0) ? n - 1 : k;
    for (int i = 0; i <= int'(stop); i++) begin
      phi = base + step * 32'(i);
      if (mode != 0 && i == int'(stop)) push(EV_TUNED, phi, 16'(i), (mode == 3) ? 1'b0 : 1'b1, 0);
      else push(EV_TUNED, phi, 16'(i), 1'b1, d);
    end
    if (mode == 0) push(EV_DONE, phi, 16'(n - 1), 1'b0, 0);
    m_idx = 16'(stop);
    m_phi = phi;
    sweep_base = base; sweep_step = step; sweep_count = count; sweep_dwell = dwell;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    if (mode == 1) begin
      wait_point(16'(k), 1'b1);
      hphi = $urandom;
      do_host(hphi, 1'b1);
    end else if (mode >= 2) begin
      wait_point(16'(k), (mode == 2) ? 1'b1 : 1'b0);
      sweep_abort = 1'b1;
      @(posedge clk); #1;
      sweep_abort = 1'b0;
    end
    drain();
    hold_check();
  endtask

  task automatic start_with_host(input logic [31:0] hphi);
    push(EV_ACK, hphi, m_idx, 1'b0, 0);
    push(EV_TUNED, hphi, m_idx, 1'b0, 0);
    sweep_base = $urandom | 32'd1; sweep_step = $urandom;
    sweep_count = 16'(3); sweep_dwell = 16'(2);
    host_phi = hphi; host_req = 1'b1; sweep_start = 1'b1;
    @(posedge clk); #1;
    host_req = 1'b0; sweep_start = 1'b0;
    m_phi = hphi;
    check("start_lost_busy", 32'(sweep_busy), 32'd0);
    drain();
    hold_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phi"}, nco_phi_inc, 32'd0);
    check({tag, "_clken"}, 32'(nco_clken), 32'd0);
    check({tag, "_tuned"}, 32'(tuned), 32'd0);
    check({tag, "_ack"}, 32'(host_ack), 32'd0);
    check({tag, "_busy"}, 32'(sweep_busy), 32'd0);
    check({tag, "_done"}, 32'(sweep_done), 32'd0);
    check({tag, "_idx"}, 32'(step_idx), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=time limit reached expected=bench completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int unsigned kind, cnt;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    check("clken_before_edge", 32'(nco_clken), 32'd0);
    @(posedge clk); #1;
    check("clken_after_edge", 32'(nco_clken), 32'd1);

    do_host(32'h0F5C28F6, 1'b1);
    check("host_phi_next_cycle", nco_phi_inc, 32'h0F5C28F6);
    drain();
    hold_check();

    run_sweep(32'h1000_0000, 32'h0100_0000, 16'd4, 16'd8, 0, 0);
    run_sweep(32'hFF00_0000, 32'h0100_0000, 16'd3, 16'd3, 0, 0);
    run_sweep(32'h2000_0000, 32'h0010_0000, 16'd4, 16'd5, 1, 2);
    run_sweep(32'h3000_0000, 32'hFFF0_0000, 16'd4, 16'd6, 2, 1);
    start_with_host(32'h1234_5678);

    sweep_abort = 1'b1;
    @(posedge clk); #1;
    sweep_abort = 1'b0;
    hold_check();

    valid_force0 = 1'b1;
    do_host(32'h0ABC_DEF0, 1'b1);
    repeat (40) @(negedge clk);
    check("tuned_no_valid", 32'(tuned), 32'd0);
    valid_force0 = 1'b0;
    drain();
    hold_check();

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 7);
      cnt  = $urandom_range(0, 5);
      case (kind)
        0: begin do_host($urandom, 1'b1); drain(); hold_check(); end
        1: run_sweep($urandom | 32'd1, $urandom, 16'(cnt), 16'($urandom_range(0, 5)), 0, 0);
        2, 3, 4: run_sweep($urandom | 32'd1, $urandom, 16'(cnt), 16'($urandom_range(0, 5)), int'(kind) - 1,
                           $urandom_range(0, (cnt == 0) ? 0 : cnt - 1));
        5: start_with_host($urandom);
        6: begin
          do_host($urandom, 1'b0);
          repeat ($urandom_range(1, 8)) @(posedge clk);
          #1;
          do_host($urandom, 1'b1);
          drain();
          hold_check();
        end
        default: begin
          sweep_abort = 1'b1;
          @(posedge clk); #1;
          sweep_abort = 1'b0;
          hold_check();
        end
      endcase
    end

    run_sweep(32'h4000_0000, 32'h0100_0000, 16'd4, 16'd4, 0, 0);
    push(EV_TUNED, 32'h5000_0000, 16'd0, 1'b1, 4);
    push(EV_TUNED, 32'h5100_0000, 16'd1, 1'b1, 4);
    sweep_base = 32'h5000_0000; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    m_idx = '0;
    m_phi = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("clken_after_rereset", 32'(nco_clken), 32'd1);
    do_host(32'h0765_4321, 1'b1);
    drain();
    hold_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
